instruction_issuer: RTL and testbench

INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

---
 rtl/instruction_issuer.sv | 135 +++++++++++++
 tb/tb_instruction_issuer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// Buffers host instructions in a FIFO and issues them one at a time to a core via a start/busy handshake.
// Optional ack timeout (drop instruction, set sticky timeout_err) is enabled by defining ISSUER_TIMEOUT_EN.
module instruction_issuer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DEPTH             = 8,
  parameter int ACK_TIMEOUT       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] load_instr,
  output logic                         load_ready,
  input  logic                         go,
  input  logic                         core_busy,
  output logic [INSTRUCTION_WIDTH-1:0] core_instruction,
  output logic                         core_start,
  output logic                         issuing,
  output logic [7:0]                   retired_count,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_issuer: DEPTH must be a power of two in 2..256");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("instruction_issuer: ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                         state, state_next;
  logic [INSTRUCTION_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]                  rd_ptr, wr_ptr;
  logic [CW-1:0]                  count;
  logic                           full, empty, push, pop;
  logic                           retire, drop, last_entry;
  logic                           clear_retired, go_empty_q, ack_expired;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop        = retire || drop;
  // A retiring slot frees space this very cycle, so a full buffer still accepts a push.
  assign load_ready = !full || pop;
  assign push       = load_valid && load_ready;
  assign last_entry = (count == CW'(1)) && !push;

  assign issuing          = (state != IDLE);
  assign core_instruction = empty ? '0 : mem[rd_ptr];
  assign done             = go_empty_q || (pop && last_entry);

  always_comb begin
    state_next    = state;
    core_start    = 1'b0;
    retire        = 1'b0;
    drop          = 1'b0;
    clear_retired = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          clear_retired = 1'b1;
          if (!empty) state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!core_busy) begin
          core_start = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (core_busy) state_next = WAIT_DONE;
        else if (ack_expired) drop = 1'b1;
      end
      WAIT_DONE: begin
        if (!core_busy) retire = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (retire || drop) state_next = last_entry ? IDLE : ISSUE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= load_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      retired_count <= '0;
      go_empty_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (clear_retired) retired_count <= '0;
      else if (retire)   retired_count <= retired_count + 8'd1;
      // go on an empty buffer reports completion on the following cycle
      go_empty_q <= (state == IDLE) && go && empty;
    end
  end

`ifdef ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] ack_cnt;

  assign ack_expired = (ack_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT_ACK && state_next == WAIT_ACK) ack_cnt <= ack_cnt + TW'(1);
      else                                             ack_cnt <= '0;
      if (drop) timeout_err <= 1'b1;
    end
  end
`else
  assign ack_expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_issuer.sv
// Randomized and directed bench for instruction_issuer with a queue-based reference model of the issue protocol.
module tb_instruction_issuer;
  localparam int IW = 16;
  localparam int DEPTH = 8;
  localparam int ACK_TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset, load_valid, go, core_busy;
  logic [IW-1:0] load_instr, core_instruction;
  logic          load_ready, core_start, issuing, done, timeout_err;
  logic [7:0]    retired_count;

  instruction_issuer #(.INSTRUCTION_WIDTH(IW), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(load_ready), .go(go), .core_busy(core_busy),
    .core_instruction(core_instruction), .core_start(core_start), .issuing(issuing),
    .retired_count(retired_count), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending instructions plus where the head is in the core handshake.
  logic [IW-1:0] q[$];
  bit active, launched, acked, err, done_pend;
  int retired, ack_wait;

  // Core model and observations
  int busy_left = 0, exec_time = 4, cyc = 0;
  bit force_busy = 0, dead_once = 0, last_push = 0;
  int n_start, n_done;
  logic [IW-1:0] started[$];
  int start_cyc[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    active = 0; launched = 0; acked = 0; err = 0; done_pend = 0;
    retired = 0; ack_wait = 0;
  endtask

  task automatic clear_obs();
    n_start = 0; n_done = 0;
    started.delete(); start_cyc.delete();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_issuing"}, 64'(issuing), 64'(0));
    chk({tag, "_load_ready"}, 64'(load_ready), 64'(1));
    chk({tag, "_core_start"}, 64'(core_start), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_retired"}, 64'(retired_count), 64'(0));
    chk({tag, "_instr"}, 64'(core_instruction), 64'(0));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  task automatic step(input bit g, input bit lv, input logic [IW-1:0] li);
    bit retire, drop, pop, lr, push, e_start, last, e_done;
    logic [IW-1:0] e_instr;
    go = g; load_valid = lv; load_instr = li;
    core_busy = force_busy || (busy_left > 0);
    @(negedge clk);
    retire = active && acked && !core_busy;
    drop = 1'b0;
`ifdef ISSUER_TIMEOUT_EN
    drop = active && launched && !acked && !core_busy && (ack_wait + 1 == ACK_TIMEOUT);
`endif
    pop = retire || drop;
    lr = (q.size() < DEPTH) || pop;
    push = lv && lr;
    e_start = active && !launched && !core_busy;
    last = pop && (q.size() == 1) && !push;
    e_done = done_pend || last;
    e_instr = (q.size() > 0) ? q[0] : '0;
    chk("issuing", 64'(issuing), 64'(active));
    chk("load_ready", 64'(load_ready), 64'(lr));
    chk("core_start", 64'(core_start), 64'(e_start));
    chk("done", 64'(done), 64'(e_done));
    chk("retired_count", 64'(retired_count), 64'(retired));
    chk("core_instruction", 64'(core_instruction), 64'(e_instr));
    chk("timeout_err", 64'(timeout_err), 64'(err));
    if (busy_left > 0) busy_left--;
    if (core_start === 1'b1) begin
      n_start++;
      started.push_back(core_instruction);
      start_cyc.push_back(cyc);
      if (dead_once) dead_once = 0;
      else busy_left = exec_time;
    end
    if (done === 1'b1) n_done++;
    last_push = push;
    done_pend = !active && g && (q.size() == 0);
    if (!active) begin
      if (g) begin
        retired = 0;
        if (q.size() > 0) begin active = 1; launched = 0; acked = 0; end
      end
    end else begin
      if (e_start) begin launched = 1; ack_wait = 0; end
      else if (launched && !acked) begin
        if (core_busy) acked = 1;
        else ack_wait++;
      end
      if (pop) begin
        void'(q.pop_front());
        launched = 0; acked = 0;
        if (retire) retired = (retired + 1) % 256;
        if (drop) err = 1;
        if (last) active = 0;
      end
    end
    if (push) q.push_back(li);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int k = 0;
    while ((active || done_pend) && k < bound) begin
      step(0, 0, '0);
      k++;
    end
    chk({name, "_drain_in_budget"}, 64'(active || done_pend), 64'(0));
    step(0, 0, '0);
    step(0, 0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; go = 0; load_valid = 0; load_instr = '0; core_busy = 0;
    model_reset();
    clear_obs();
    @(posedge clk); #1;
    reset_checks("por");
    reset = 1'b1;

    // Three instructions, core busy 4 cycles per start
    exec_time = 4;
    step(0, 1, 16'h0A01);
    step(0, 1, 16'h0B02);
    step(0, 1, 16'h0C03);
    step(1, 0, '0);
    run_until_idle(100, "three");
    chk("three_starts", 64'(n_start), 64'(3));
    chk("three_instr0", 64'(started[0]), 64'(16'h0A01));
    chk("three_instr1", 64'(started[1]), 64'(16'h0B02));
    chk("three_instr2", 64'(started[2]), 64'(16'h0C03));
    chk("three_retired", 64'(retired_count), 64'(3));
    chk("three_done_pulses", 64'(n_done), 64'(1));
    chk("three_start_spacing", 64'(start_cyc[1] - start_cyc[0]), 64'(6));

    // Full buffer, refused 9th load, push accepted on the pop cycle
    clear_obs();
    for (int i = 0; i < DEPTH; i++) step(0, 1, IW'(16'h0100 + i));
    step(0, 1, 16'h01FF);
    chk("full_load_ready", 64'(load_ready), 64'(0));
    step(1, 0, '0);
    begin
      int k = 0;
      last_push = 0;
      while (!last_push && k < 100) begin step(0, 1, 16'h02AA); k++; end
    end
    chk("full_occupancy_after_swap", 64'(q.size()), 64'(8));
    chk("full_ready_after_swap", 64'(load_ready), 64'(0));
    run_until_idle(300, "full");
    chk("full_starts", 64'(n_start), 64'(9));
    chk("full_first", 64'(started[0]), 64'(16'h0100));
    chk("full_last", 64'(started[8]), 64'(16'h02AA));
    chk("full_retired", 64'(retired_count), 64'(9));

    // go on an empty buffer
    clear_obs();
    step(1, 0, '0);
    run_until_idle(10, "empty");
    chk("empty_done_pulses", 64'(n_done), 64'(1));
    chk("empty_starts", 64'(n_start), 64'(0));
    chk("empty_retired", 64'(retired_count), 64'(0));

    // Core already busy at go
    clear_obs();
    step(0, 1, 16'h0E0E);
    force_busy = 1;
    step(1, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("busy_hold_no_start", 64'(n_start), 64'(0));
    force_busy = 0;
    run_until_idle(50, "busy");
    chk("busy_starts", 64'(n_start), 64'(1));

    // Reset in WAIT_DONE with two entries left
    clear_obs();
    step(0, 1, 16'h0F01);
    step(0, 1, 16'h0F02);
    step(0, 1, 16'h0F03);
    step(1, 0, '0);
    begin
      int k = 0;
      while (!(retired == 1 && acked) && k < 100) begin step(0, 0, '0); k++; end
    end
    chk("midrst_reached_wait_done", 64'(q.size()), 64'(2));
    reset = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, '0);
    chk("midrst_no_start", 64'(n_start), 64'(2));
    step(0, 1, 16'h0F0F);
    step(1, 0, '0);
    run_until_idle(50, "midrst");
    chk("midrst_restart", 64'(n_start), 64'(3));
    chk("midrst_restart_instr", 64'(started[2]), 64'(16'h0F0F));

`ifdef ISSUER_TIMEOUT_EN
    // Core ignores the first start: that instruction is dropped
    do_reset();
    clear_obs();
    dead_once = 1;
    step(0, 1, 16'h0D01);
    step(0, 1, 16'h0D02);
    step(1, 0, '0);
    run_until_idle(200, "tmo");
    chk("tmo_err", 64'(timeout_err), 64'(1));
    chk("tmo_retired", 64'(retired_count), 64'(1));
    chk("tmo_starts", 64'(n_start), 64'(2));
    chk("tmo_second", 64'(started[1]), 64'(16'h0D02));
`endif

    // Random traffic
    do_reset();
    clear_obs();
    for (int i = 0; i < 1500; i++) begin
      exec_time = $urandom_range(1, 6);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, IW'($urandom));
    end
    run_until_idle(2000, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
